// File: rtl/xor_implies_skolem_engine_pkg.sv
// rtl/xor_implies_skolem_engine_pkg.sv - shared mode encoding for the xor-implies Skolem engine
package xor_implies_pkg;

  // Per-vector operating mode, sampled with each accepted input.
  typedef enum logic {
    MODE_SYNTH = 1'b0,
    MODE_CHECK = 1'b1
  } mode_e;

endpackage

// File: rtl/xor_implies_skolem_engine_lowest_zero_finder.sv
// rtl/xor_implies_skolem_engine_lowest_zero_finder.sv - index of the lowest zero bit of a vector
module lowest_zero_finder #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!vec_i[i]) begin
        idx_o  = IW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xor_implies_skolem_engine.sv
// rtl/xor_implies_skolem_engine.sv - streaming witness synthesiser / checker for the xor-implies family
module xor_implies_skolem_engine
  import xor_implies_pkg::*;
#(
  parameter int N      = 8,
  parameter bit PARITY = 1'b0,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  input  logic [N-1:0]  in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_x,
  output logic [N-1:0]  out_y,
  output logic          out_sat,
  output logic          out_unreal,
  input  logic          clear_stats,
  output logic [CW-1:0] cnt_total,
  output logic [CW-1:0] cnt_unreal,
  output logic [CW-1:0] cnt_viol
);

  localparam int   IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic N_ODD = 1'(N % 2);

  // Stage payloads; S2 keeps the mode so violations can be attributed to check-mode results.
  typedef struct packed {
    mode_e        mode;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         unreal;
  } s1_t;

  typedef struct packed {
    mode_e        mode;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sat;
    logic         unreal;
  } s2_t;

  logic          s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  s1_t           s1_q, s1_d, cand;
  s2_t           s2_q, s2_d;
  logic [CW-1:0] tot_q, tot_d, unr_q, unr_d, viol_q, viol_d;
  logic          s2_free, accept, xfer, s1_sat;
  logic [IW-1:0] zero_idx;
  logic          zero_none;

  lowest_zero_finder #(.N(N), .IW(IW)) u_lzf (
    .vec_i  (in_x),
    .idx_o  (zero_idx),
    .none_o (zero_none)
  );

  // Candidate y: all ones fixes every implication; clearing one bit where x is 0 repairs parity.
  always_comb begin
    cand      = '0;
    cand.mode = mode_e'(mode);
    cand.x    = in_x;
    if (mode_e'(mode) == MODE_CHECK) begin
      cand.y = in_y;
    end else begin
      cand.y = '1;
      if (((^in_x) ^ N_ODD) != PARITY) begin
        if (zero_none) cand.unreal = 1'b1;
        else           cand.y[zero_idx] = 1'b0;
      end
    end
  end

  // phi evaluated on the S1 contents as they move into S2.
  assign s1_sat = (((^s1_q.x) ^ (^s1_q.y)) == PARITY) & ~|(s1_q.x & ~s1_q.y);

  // Handshake and stage-advance decisions.
  always_comb begin
    s2_free  = !s2_v_q || out_ready;
    in_ready = !s1_v_q || s2_free;
    accept   = in_valid && in_ready;
    xfer     = s2_v_q && out_ready;
    s1_v_d   = accept ? 1'b1 : (s2_free ? 1'b0 : s1_v_q);
    s1_d     = accept ? cand : s1_q;
    s2_v_d   = s2_free ? s1_v_q : s2_v_q;
    s2_d     = s2_q;
    if (s2_free && s1_v_q) begin
      s2_d.mode   = s1_q.mode;
      s2_d.x      = s1_q.x;
      s2_d.y      = s1_q.y;
      s2_d.sat    = s1_sat;
      s2_d.unreal = s1_q.unreal;
    end
  end

  // Saturating statistics; a clear in the same cycle swallows the transfer.
  always_comb begin
    tot_d  = tot_q;
    unr_d  = unr_q;
    viol_d = viol_q;
    if (clear_stats) begin
      tot_d  = '0;
      unr_d  = '0;
      viol_d = '0;
    end else if (xfer) begin
      if (~&tot_q) tot_d = tot_q + 1'b1;
      if (s2_q.unreal && ~&unr_q) unr_d = unr_q + 1'b1;
      if (s2_q.mode == MODE_CHECK && !s2_q.sat && ~&viol_q) viol_d = viol_q + 1'b1;
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      tot_q  <= '0;
      unr_q  <= '0;
      viol_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      tot_q  <= tot_d;
      unr_q  <= unr_d;
      viol_q <= viol_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_x      = s2_q.x;
  assign out_y      = s2_q.y;
  assign out_sat    = s2_q.sat;
  assign out_unreal = s2_q.unreal;
  assign cnt_total  = tot_q;
  assign cnt_unreal = unr_q;
  assign cnt_viol   = viol_q;

endmodule

// File: tb/tb_xor_implies_skolem_engine.sv
// tb/tb_xor_implies_skolem_engine.sv - self-checking bench for xor_implies_skolem_engine
module tb_xor_implies_skolem_engine;

  typedef struct packed {
    logic [7:0] y;
    logic       sat;
    logic       unreal;
  } res_t;

  typedef struct {
    bit         m;
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, mode, in_valid, out_ready, clear_stats;
  logic [7:0] in_x, in_y;
  logic       ir0, ov0, os0, ou0, ir1, ov1, os1, ou1;
  logic [7:0] ox0, oy0, ox1, oy1;
  logic [15:0] ct0, cu0, cv0, ct1, cu1, cv1;

  int         checks = 0;
  int         errors = 0;
  vec_t       q[$];
  res_t       log0[$], log1[$];
  logic [15:0] mt[2], mu[2], mv[2];
  bit         lat_on = 1'b0;
  bit [1:0]   hist = 2'b00;

  always #5 clk = ~clk;

  xor_implies_skolem_engine #(.N(8), .PARITY(1'b0), .CW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir0),
    .in_x(in_x), .in_y(in_y), .out_valid(ov0), .out_ready(out_ready),
    .out_x(ox0), .out_y(oy0), .out_sat(os0), .out_unreal(ou0),
    .clear_stats(clear_stats), .cnt_total(ct0), .cnt_unreal(cu0), .cnt_viol(cv0)
  );

  xor_implies_skolem_engine #(.N(8), .PARITY(1'b1), .CW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir1),
    .in_x(in_x), .in_y(in_y), .out_valid(ov1), .out_ready(out_ready),
    .out_x(ox1), .out_y(oy1), .out_sat(os1), .out_unreal(ou1),
    .clear_stats(clear_stats), .cnt_total(ct1), .cnt_unreal(cu1), .cnt_viol(cv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: start from all ones; if the total parity is wrong, drop the lowest bit where x is 0.
  function automatic res_t model(input bit par, input bit m, input logic [7:0] x, input logic [7:0] yi);
    res_t       r;
    logic [7:0] nx, lb;
    r.unreal = 1'b0;
    if (m) begin
      r.y = yi;
    end else begin
      r.y = 8'hFF;
      if ((($countones(x) + 8) % 2) != int'(par)) begin
        if (x == 8'hFF) begin
          r.unreal = 1'b1;
        end else begin
          nx  = ~x;
          lb  = nx & (8'd0 - nx);
          r.y = r.y & ~lb;
        end
      end
    end
    r.sat = ((($countones(x) + $countones(r.y)) % 2) == int'(par)) && ((x & ~r.y) == 8'h00);
    return r;
  endfunction

  task automatic count(input int d, input res_t r, input bit m);
    if (mt[d] != 16'hFFFF) mt[d] = mt[d] + 16'd1;
    if (r.unreal && mu[d] != 16'hFFFF) mu[d] = mu[d] + 16'd1;
    if (m && !r.sat && mv[d] != 16'hFFFF) mv[d] = mv[d] + 16'd1;
  endtask

  // One clock cycle: drive, observe the pre-edge handshake, clock, then compare counters.
  task automatic step(input bit iv, input bit m, input logic [7:0] x, input logic [7:0] y,
                      input bit ordy, input bit clr, input bit rst, output bit acc_o);
    bit   acc, xf;
    vec_t e;
    res_t r0, r1;
    in_valid = iv; mode = m; in_x = x; in_y = y;
    out_ready = ordy; clear_stats = clr; rst_n = !rst;
    #2;
    acc = 1'b0;
    if (!rst) begin
      acc = in_valid && ir0;
      xf  = ov0 && out_ready;
      chk("in_ready0", 32'(ir0), 32'(!(q.size() == 2 && !ordy)));
      chk("in_ready1", 32'(ir1), 32'(!(q.size() == 2 && !ordy)));
      if (lat_on) begin
        chk("latency0", 32'(ov0), 32'(hist[1]));
        chk("latency1", 32'(ov1), 32'(hist[1]));
      end
      if (xf) begin
        chk("out_has_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e  = q.pop_front();
          r0 = model(1'b0, e.m, e.x, e.y);
          r1 = model(1'b1, e.m, e.x, e.y);
          chk("out_x0", 32'(ox0), 32'(e.x));
          chk("out_y0", 32'(oy0), 32'(r0.y));
          chk("out_sat0", 32'(os0), 32'(r0.sat));
          chk("out_unreal0", 32'(ou0), 32'(r0.unreal));
          chk("out_x1", 32'(ox1), 32'(e.x));
          chk("out_y1", 32'(oy1), 32'(r1.y));
          chk("out_sat1", 32'(os1), 32'(r1.sat));
          chk("out_unreal1", 32'(ou1), 32'(r1.unreal));
          log0.push_back(res_t'{oy0, os0, ou0});
          log1.push_back(res_t'{oy1, os1, ou1});
          if (!clr) begin
            count(0, r0, e.m);
            count(1, r1, e.m);
          end
        end
      end
      if (clr) begin
        mt = '{16'd0, 16'd0}; mu = '{16'd0, 16'd0}; mv = '{16'd0, 16'd0};
      end
      if (acc) q.push_back(vec_t'{m, x, y});
      hist = {hist[0], acc};
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      mt = '{16'd0, 16'd0}; mu = '{16'd0, 16'd0}; mv = '{16'd0, 16'd0};
      hist = 2'b00;
    end
    #1;
    chk("cnt_total0", 32'(ct0), 32'(mt[0]));
    chk("cnt_unreal0", 32'(cu0), 32'(mu[0]));
    chk("cnt_viol0", 32'(cv0), 32'(mv[0]));
    chk("cnt_total1", 32'(ct1), 32'(mt[1]));
    chk("cnt_unreal1", 32'(cu1), 32'(mu[1]));
    chk("cnt_viol1", 32'(cv1), 32'(mv[1]));
    acc_o = acc;
  endtask

  task automatic lit(input string tag, input res_t obs, input logic [7:0] y, input bit sat, input bit un);
    chk({tag, "_y"}, 32'(obs.y), 32'(y));
    chk({tag, "_sat"}, 32'(obs.sat), 32'(sat));
    chk({tag, "_unreal"}, 32'(obs.unreal), 32'(un));
  endtask

  task automatic flush();
    bit a;
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, a);
  endtask

  initial begin
    bit         a;
    int         sent;
    logic [7:0] t1x[4];
    logic [7:0] t1y[4];
    mt = '{16'd0, 16'd0}; mu = '{16'd0, 16'd0}; mv = '{16'd0, 16'd0};

    // Reset state
    repeat (2) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, a);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_x", 32'(ox0), 32'd0);
    chk("rst_out_y", 32'(oy0), 32'd0);
    chk("rst_out_sat", 32'(os0), 32'd0);
    chk("rst_out_unreal", 32'(ou0), 32'd0);
    chk("rst_in_ready", 32'(ir0), 32'd1);

    // Test 1: synth mode, PARITY=0, back-to-back with latency tracking
    t1x = '{8'h00, 8'h01, 8'h7F, 8'hFF};
    t1y = '{8'hFF, 8'hFD, 8'h7F, 8'hFF};
    log0.delete(); log1.delete();
    lat_on = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, t1x[i], 8'h00, 1'b1, 1'b0, 1'b0, a);
    flush();
    lat_on = 1'b0;
    for (int i = 0; i < 4; i++) lit("t1", log0[i], t1y[i], 1'b1, 1'b0);
    chk("t1_cnt_total", 32'(ct0), 32'd4);

    // Test 2: synth mode, PARITY=1 (second instance)
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, a);
    log0.delete(); log1.delete();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, a);
    flush();
    lit("t2a", log1[0], 8'hFE, 1'b1, 1'b0);
    lit("t2b", log1[1], 8'hFF, 1'b0, 1'b1);
    chk("t2_cnt_unreal", 32'(cu1), 32'd1);

    // Test 3: check mode, PARITY=0
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, a);
    log0.delete(); log1.delete();
    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, a);
    flush();
    lit("t3a", log0[0], 8'h00, 1'b0, 1'b0);
    chk("t3a_cnt_viol", 32'(cv0), 32'd1);
    step(1'b1, 1'b1, 8'h01, 8'hFD, 1'b1, 1'b0, 1'b0, a);
    flush();
    lit("t3b", log0[1], 8'hFD, 1'b1, 1'b0);
    chk("t3b_cnt_viol", 32'(cv0), 32'd1);

    // Test 4: random vectors under random backpressure
    sent = 0;
    for (int k = 0; k < 300 && (sent < 10 || q.size() != 0); k++) begin
      step(sent < 10, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 1'b0, 1'b0, a);
      if (a) sent++;
    end
    chk("t4_sent", 32'(sent), 32'd10);
    chk("t4_drained", 32'(q.size()), 32'd0);

    // Test 5: reset with both stages full
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 8'h78, 8'h00, 1'b0, 1'b0, 1'b0, a);
    chk("t5_full", 32'(q.size()), 32'd2);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, a);
    chk("t5_out_valid", 32'(ov0), 32'd0);
    chk("t5_in_ready", 32'(ir0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, a);
      chk("t5_no_ghost", 32'(ov0), 32'd0);
    end

    // Test 6: saturation and clear-vs-transfer priority
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, a);
    for (int k = 0; k < 70000 && mt[0] != 16'hFFFE; k++)
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, a);
    chk("t6_preload", 32'(ct0), 32'hFFFE);
    repeat (3) step(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1, 1'b0, 1'b0, a);
    chk("t6_saturated", 32'(ct0), 32'hFFFF);
    chk("t6_xfer_pending", 32'(ov0), 32'd1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, a);
    chk("t6_clr_total0", 32'(ct0), 32'd0);
    chk("t6_clr_unreal1", 32'(cu1), 32'd0);
    chk("t6_clr_viol0", 32'(cv0), 32'd0);
    chk("t6_clr_total1", 32'(ct1), 32'd0);
    flush();
    chk("t6_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
